// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_pkg
//  Purpose  : Shared constants, state encodings and types for the fetch unit
//  Revision : 1.0  initial release
// ============================================================================
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

    // Fetch FSM encodings
    localparam logic [1:0] IFU_REQ  = 2'd0;   // request phase
    localparam logic [1:0] IFU_WAIT = 2'd1;   // granted, awaiting response
    localparam logic [1:0] IFU_DROP = 2'd2;   // awaiting a response to discard

    // Instruction word paired with the address it was fetched from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } fetch_pkt_t;

    // Instructions are word aligned; the low two address bits are dropped
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_if
//  Purpose  : Request/grant/response instruction bus
//  Revision : 1.0  initial release
// ============================================================================
interface ifu_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    // Fetch unit side
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Memory side
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/ifu_skid.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_skid
//  Purpose  : Registered output stage with a one-entry skid buffer behind it
//  Revision : 1.0  initial release
// ============================================================================
module ifu_skid
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        hold,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        full
);

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q,  out_data_d;
    logic        skid_valid_q, skid_valid_d;
    logic [63:0] skid_data_q,  skid_data_d;
    logic        consume;

    assign consume = out_valid_q && !hold;

    // Next state: flush wins; a consume drains the skid first, otherwise
    // incoming data lands in the output register if free, else in the skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_data_d = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (in_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end
        end else if (in_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Output and skid registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {ZERO_WORD, ZERO_WORD};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {ZERO_WORD, ZERO_WORD};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign full      = skid_valid_q;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ifu
//  Purpose  : Instruction fetch unit - PC, single-outstanding fetch FSM,
//             jump redirect and skid-buffered delivery to decode
//  Revision : 1.0  initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        hold_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    ifu_if.master       ibus,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;

    logic        req;
    logic        grant;
    logic        deliver;
    logic        skid_full;
    fetch_pkt_t  in_pkt;
    fetch_pkt_t  out_pkt;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IFU_REQ;
        else      state_q <= state_d;
    end

    // FSM next state; a jump in WAIT without data must still swallow the
    // response already owed by the bus
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_REQ:  if (grant)          state_d = IFU_WAIT;
            IFU_WAIT: if (ibus.rvalid)    state_d = IFU_REQ;
                      else if (jump_i)    state_d = IFU_DROP;
            IFU_DROP: if (ibus.rvalid)    state_d = IFU_REQ;
            default:                      state_d = IFU_REQ;
        endcase
    end

    // FSM outputs; requests stall while the skid holds an instruction so the
    // skid can never overflow
    always_comb begin
        req     = (state_q == IFU_REQ) && !jump_i && !skid_full;
        grant   = req && ibus.gnt;
        deliver = (state_q == IFU_WAIT) && ibus.rvalid && !jump_i;
    end

    // PC and in-flight fetch address next values; jump overrides everything
    always_comb begin
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        if (jump_i) begin
            pc_d = align_word(jump_addr_i);
        end else if (grant) begin
            pc_d         = pc_q + 32'd4;
            fetch_addr_d = pc_q;
        end
    end

    // PC and fetch address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            fetch_addr_q <= ZERO_WORD;
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    assign ibus.req  = req;
    assign ibus.addr = pc_q;

    assign in_pkt.inst = ibus.rdata;
    assign in_pkt.addr = fetch_addr_q;

    ifu_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (deliver),
        .in_data   (in_pkt),
        .hold      (hold_i),
        .flush     (jump_i),
        .out_valid (inst_valid_o),
        .out_data  (out_pkt),
        .full      (skid_full)
    );

    assign inst_o      = out_pkt.inst;
    assign inst_addr_o = out_pkt.addr;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu
//  Purpose  : Self-checking bench for ifu with a memory responder and an
//             in-order instruction-stream reference model
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        hold_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    ifu_if bus();

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_i       (hold_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .ibus         (bus),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder state
    int          gnt_pct;
    int          lat;
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;

    // reference model: next fetch address and next instruction id must accept
    logic [31:0] pc_m;
    logic [31:0] exp_next;
    int          consumed;
    bit          prev_frozen;
    logic [31:0] prev_inst;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // drive bus inputs for the current cycle, then let combinational paths settle
    task automatic drive();
        if (pend) begin
            cnt--;
            bus.rvalid = (cnt == 0);
        end else begin
            bus.rvalid = 1'b0;
        end
        bus.rdata = bus.rvalid ? mem(pend_addr) : $urandom;
        bus.gnt   = ($urandom_range(0, 99) < gnt_pct);
        #1;
    endtask

    // scoreboard the current cycle, advance one clock, update the responder
    task automatic edge_step();
        bit          granted;
        bit          rv;
        logic [31:0] gaddr;
        granted = bus.req && bus.gnt;
        rv      = bus.rvalid;
        gaddr   = bus.addr;
        if (rst) begin
            n_checks++;
            if (bus.addr !== pc_m) begin
                n_fail++; $display("FAIL sb_fetch_addr: ibus_addr=%h want %h", bus.addr, pc_m);
            end
            if (granted) begin
                n_checks++;
                if (pend) begin
                    n_fail++; $display("FAIL sb_one_outstanding: grant with fetch pending=%0d want 0", pend);
                end
            end
            n_checks++;
            if ((dut.deliver && dut.skid_full) !== 1'b0) begin
                n_fail++; $display("FAIL sb_deliver_into_full_skid: got %b want 0", dut.deliver && dut.skid_full);
            end
            if (prev_frozen) begin
                n_checks++;
                if (inst_valid_o !== 1'b1 || inst_addr_o !== prev_addr || inst_o !== prev_inst) begin
                    n_fail++;
                    $display("FAIL sb_hold_freeze: valid=%b addr=%h inst=%h want 1 %h %h",
                             inst_valid_o, inst_addr_o, inst_o, prev_addr, prev_inst);
                end
            end
            if (inst_valid_o && !hold_i) begin
                n_checks++;
                if (inst_addr_o !== exp_next || inst_o !== mem(exp_next)) begin
                    n_fail++;
                    $display("FAIL sb_stream: addr=%h inst=%h want %h %h",
                             inst_addr_o, inst_o, exp_next, mem(exp_next));
                end
                exp_next = exp_next + 32'd4;
                consumed++;
            end
            prev_frozen = inst_valid_o && hold_i && !jump_i;
            prev_addr   = inst_addr_o;
            prev_inst   = inst_o;
            if (jump_i) begin
                pc_m     = {jump_addr_i[31:2], 2'b00};
                exp_next = pc_m;
            end else if (granted) begin
                pc_m = pc_m + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        if (rv) pend = 1'b0;
        if (granted) begin
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = gaddr;
        end
    endtask

    task automatic tick();
        drive();
        edge_step();
    endtask

    task automatic apply_reset();
        rst         = 1'b0;
        hold_i      = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        bus.gnt     = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        pend        = 1'b0;
        cnt         = 0;
        pc_m        = RST_PC;
        exp_next    = RST_PC;
        prev_frozen = 1'b0;
        gnt_pct     = 100;
        lat         = 1;
    endtask

    // run until the first valid output and check it is the expected address
    task automatic wait_first_valid(input logic [31:0] want);
        for (int i = 0; i < 30; i++) begin
            drive();
            if (inst_valid_o) begin
                n_checks++;
                if (inst_addr_o !== want || inst_o !== mem(want)) begin
                    n_fail++;
                    $display("FAIL first_valid: addr=%h inst=%h want %h %h", inst_addr_o, inst_o, want, mem(want));
                end
                edge_step();
                return;
            end
            edge_step();
        end
        n_checks++; n_fail++;
        $display("FAIL first_valid_timeout: no valid output within 30 cycles, want addr %h", want);
    endtask

    task automatic test_reset();
        rst = 1'b0; hold_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        if (inst_o !== 32'h0)      begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr_o); end
        if (bus.addr !== RST_PC)   begin n_fail++; $display("FAIL reset_ibus_addr: got %h want %h", bus.addr, RST_PC); end
        apply_reset();
        gnt_pct = 0;
        drive();
        n_checks += 2;
        if (bus.req !== 1'b1)    begin n_fail++; $display("FAIL reset_first_req: got %b want 1", bus.req); end
        if (bus.addr !== RST_PC) begin n_fail++; $display("FAIL reset_first_addr: got %h want %h", bus.addr, RST_PC); end
        edge_step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        apply_reset();
        for (int c = 1; c <= 7; c++) begin
            drive();
            n_checks += 2;
            if (bus.req !== ((c % 2) == 1)) begin
                n_fail++; $display("FAIL zw_req c%0d: got %b want %b", c, bus.req, (c % 2) == 1);
            end
            if (inst_valid_o !== (c >= 3 && (c % 2) == 1)) begin
                n_fail++; $display("FAIL zw_valid c%0d: got %b want %b", c, inst_valid_o, c >= 3 && (c % 2) == 1);
            end
            if ((c % 2) == 1) begin
                a = 32'((c - 1) * 2);
                n_checks++;
                if (bus.addr !== a) begin n_fail++; $display("FAIL zw_addr c%0d: got %h want %h", c, bus.addr, a); end
            end
            if (c >= 3 && (c % 2) == 1) begin
                a = 32'((c - 3) * 2);
                n_checks++;
                if (inst_addr_o !== a || inst_o !== mem(a)) begin
                    n_fail++; $display("FAIL zw_out c%0d: addr=%h inst=%h want %h %h", c, inst_addr_o, inst_o, a, mem(a));
                end
            end
            edge_step();
        end
    endtask

    task automatic test_grant_withheld();
        apply_reset();
        gnt_pct = 0;
        for (int c = 1; c <= 3; c++) begin
            drive();
            n_checks++;
            if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
                n_fail++; $display("FAIL gw_wait c%0d: req=%b addr=%h want 1 0", c, bus.req, bus.addr);
            end
            edge_step();
        end
        gnt_pct = 100;
        drive();
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
            n_fail++; $display("FAIL gw_grant: req=%b addr=%h want 1 0", bus.req, bus.addr);
        end
        edge_step();
        drive();
        n_checks++;
        if (bus.req !== 1'b0 || bus.addr !== 32'h4) begin
            n_fail++; $display("FAIL gw_after: req=%b addr=%h want 0 4", bus.req, bus.addr);
        end
        edge_step();
    endtask

    task automatic test_hold_skid();
        apply_reset();
        tick(); tick();
        hold_i = 1'b1;
        drive();
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL hs_first: valid=%b addr=%h want 1 0", inst_valid_o, inst_addr_o);
        end
        edge_step();
        tick();
        drive();
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || bus.req !== 1'b0) begin
            n_fail++; $display("FAIL hs_full: valid=%b addr=%h req=%b want 1 0 0", inst_valid_o, inst_addr_o, bus.req);
        end
        edge_step();
        tick();
        hold_i = 1'b0;
        tick();
        drive();
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4 || bus.req !== 1'b1 || bus.addr !== 32'h8) begin
            n_fail++; $display("FAIL hs_release: valid=%b addr=%h req=%b faddr=%h want 1 4 1 8",
                               inst_valid_o, inst_addr_o, bus.req, bus.addr);
        end
        edge_step();
    endtask

    task automatic test_jump_wait();
        apply_reset();
        lat = 4;
        tick();
        jump_i = 1'b1; jump_addr_i = 32'h103;
        drive();
        n_checks++;
        if (bus.req !== 1'b0) begin n_fail++; $display("FAIL jw_req_during_jump: got %b want 0", bus.req); end
        edge_step();
        jump_i = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            drive();
            n_checks++;
            if (bus.req !== 1'b0 || inst_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL jw_drop c%0d: req=%b valid=%b want 0 0", c, bus.req, inst_valid_o);
            end
            edge_step();
        end
        lat = 1;
        drive();
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h100 || inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL jw_redirect: req=%b addr=%h valid=%b want 1 100 0", bus.req, bus.addr, inst_valid_o);
        end
        edge_step();
        wait_first_valid(32'h100);
    endtask

    task automatic test_jump_rvalid_full();
        // jump in the same cycle as a response while the output is held
        apply_reset();
        tick(); tick();
        hold_i = 1'b1;
        tick();
        jump_i = 1'b1; jump_addr_i = 32'h200;
        tick();
        jump_i = 1'b0;
        drive();
        n_checks++;
        if (inst_valid_o !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h200) begin
            n_fail++; $display("FAIL jr_coincide: valid=%b req=%b addr=%h want 0 1 200", inst_valid_o, bus.req, bus.addr);
        end
        edge_step();
        hold_i = 1'b0;
        wait_first_valid(32'h200);
        // jump while the skid is already full
        apply_reset();
        tick(); tick();
        hold_i = 1'b1;
        tick(); tick();
        jump_i = 1'b1; jump_addr_i = 32'h301;
        tick();
        jump_i = 1'b0;
        drive();
        n_checks++;
        if (inst_valid_o !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h300) begin
            n_fail++; $display("FAIL jr_skid_flush: valid=%b req=%b addr=%h want 0 1 300", inst_valid_o, bus.req, bus.addr);
        end
        edge_step();
        hold_i = 1'b0;
        wait_first_valid(32'h300);
    endtask

    task automatic test_async_reset_drop();
        apply_reset();
        tick(); tick();
        hold_i = 1'b1; lat = 3;
        tick();
        jump_i = 1'b1; jump_addr_i = 32'h40;
        tick();
        jump_i = 1'b0; hold_i = 1'b0;
        drive();
        #2;
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", inst_valid_o); end
        if (inst_o !== 32'h0)      begin n_fail++; $display("FAIL ar_inst: got %h want 0", inst_o); end
        if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL ar_inst_addr: got %h want 0", inst_addr_o); end
        if (bus.addr !== RST_PC)   begin n_fail++; $display("FAIL ar_ibus_addr: got %h want %h", bus.addr, RST_PC); end
        apply_reset();
        wait_first_valid(RST_PC);
    endtask

    task automatic test_random();
        apply_reset();
        consumed = 0;
        gnt_pct  = 70;
        for (int i = 0; i < 800; i++) begin
            lat         = int'($urandom_range(1, 3));
            hold_i      = ($urandom_range(0, 99) < 30);
            jump_i      = ($urandom_range(0, 99) < 4);
            jump_addr_i = $urandom;
            tick();
        end
        hold_i = 1'b0;
        jump_i = 1'b0;
        n_checks++;
        if (consumed < 40) begin
            n_fail++; $display("FAIL rnd_progress: consumed=%0d want >= 40", consumed);
        end
    endtask

    initial begin
        rst  = 1'b0;
        pend = 1'b0;
        pc_m = RST_PC;
        exp_next = RST_PC;
        prev_frozen = 1'b0;
        gnt_pct = 0;
        lat = 1;
        consumed = 0;
        test_reset();
        test_zero_wait();
        test_grant_withheld();
        test_hold_skid();
        test_jump_wait();
        test_jump_rvalid_full();
        test_async_reset_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
